// File: rtl/cm0ds_pc_trace.sv
// Program-flow trace FIFO for Cortex-M0 DesignStart visibility signals.
// Define CM0DS_PC_TRACE_TS_EN to build the delta-timestamp counter.
module cm0ds_pc_trace #(
    parameter int DEPTH = 16,
    parameter int PC_W  = 31,
    parameter int TS_W  = 16
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic [PC_W-1:0]            VIS_PC,
    input  logic [5:0]                 VIS_IPSR,
    input  logic                       LOCKUP,
    input  logic                       ENABLE,
    input  logic                       CLEAR,
    output logic                       RD_VALID,
    input  logic                       RD_READY,
    output logic [TS_W+6+PC_W-1:0]     RD_DATA,
    output logic [$clog2(DEPTH):0]     LEVEL,
    output logic                       OVERFLOW,
    output logic [7:0]                 DROPS,
    output logic                       FROZEN
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = TS_W + 6 + PC_W;

    typedef enum logic [1:0] {IDLE, PRIME, RUN, HALT} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [5:0]      ipsr_q, ipsr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      drops_q, drops_d;
    logic [DW-1:0]   mem_q [DEPTH];

    logic [PC_W-1:0] pc_step;
    logic            seq_step;
    logic            changed;
    logic            evt;
    logic            pop;
    logic            full;
    logic            push_ok;
    logic            drop;
    logic            we;
    logic [TS_W-1:0] ts_field;
    logic [DW-1:0]   wdata;

    // Steps of one or two halfwords are ordinary 16/32-bit fetches.
    always_comb begin
        pc_step  = VIS_PC - pc_q;
        seq_step = (pc_step == '0)
                || (pc_step == PC_W'(1))
                || (pc_step == PC_W'(2));
        changed  = (VIS_IPSR != ipsr_q) || !seq_step;
    end

    always_comb begin
        state_d = state_q;
        evt     = 1'b0;
        pc_d    = pc_q;
        ipsr_d  = ipsr_q;
        unique case (state_q)
            IDLE: begin
                if (ENABLE) state_d = PRIME;
            end
            PRIME: begin
                if (!ENABLE) begin
                    state_d = IDLE;
                end else begin
                    evt     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!ENABLE) begin
                    state_d = IDLE;
                end else if (LOCKUP) begin
                    evt     = 1'b1;
                    state_d = HALT;
                end else begin
                    evt = changed;
                end
            end
            HALT: begin
                if (CLEAR) state_d = ENABLE ? PRIME : IDLE;
            end
        endcase
        if (state_q == PRIME || state_q == RUN) begin
            pc_d   = VIS_PC;
            ipsr_d = VIS_IPSR;
        end
    end

`ifdef CM0DS_PC_TRACE_TS_EN
    logic [TS_W-1:0] ts_q, ts_d;

    always_comb begin
        ts_field = (state_q == PRIME) ? '0 : ts_q;
        ts_d     = ts_q;
        if (evt) begin
            ts_d = TS_W'(1);
        end else if (state_q == RUN && ts_q != '1) begin
            ts_d = ts_q + TS_W'(1);
        end
        if (CLEAR) ts_d = '0;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) ts_q <= '0;
        else        ts_q <= ts_d;
    end
`else
    always_comb ts_field = '0;
`endif

    // A full FIFO still takes a push when the head leaves in the same cycle.
    always_comb begin
        pop      = (level_q != '0) && RD_READY;
        full     = (level_q == LW'(DEPTH));
        push_ok  = evt && (!full || pop);
        drop     = evt && !push_ok;
        we       = push_ok && !CLEAR;
        wdata    = {ts_field, VIS_IPSR, VIS_PC};
        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        drops_d  = drops_q;
        if (CLEAR) begin
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            drops_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(push_ok) - LW'(pop);
            if (drop) begin
                ovf_d = 1'b1;
                if (drops_q != 8'hFF) drops_d = drops_q + 8'd1;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            ipsr_q   <= '0;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            drops_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ipsr_q   <= ipsr_d;
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            drops_q  <= drops_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (we) mem_q[wr_ptr_q] <= wdata;
    end

    always_comb begin
        RD_VALID = (level_q != '0);
        RD_DATA  = RD_VALID ? mem_q[rd_ptr_q] : '0;
        LEVEL    = level_q;
        OVERFLOW = ovf_q;
        DROPS    = drops_q;
        FROZEN   = (state_q == HALT);
    end

endmodule

// File: tb/tb_cm0ds_pc_trace.sv
// Directed bench for cm0ds_pc_trace with DEPTH=4.
module tb_cm0ds_pc_trace;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b0;
    logic [30:0] VIS_PC = '0;
    logic [5:0]  VIS_IPSR = '0;
    logic        LOCKUP = 1'b0;
    logic        ENABLE = 1'b0;
    logic        CLEAR = 1'b0;
    logic        RD_READY = 1'b0;
    logic        RD_VALID;
    logic [52:0] RD_DATA;
    logic [2:0]  LEVEL;
    logic        OVERFLOW;
    logic [7:0]  DROPS;
    logic        FROZEN;

    int total = 0;
    int bad = 0;

    cm0ds_pc_trace #(.DEPTH(4), .PC_W(31), .TS_W(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .VIS_PC(VIS_PC),
        .VIS_IPSR(VIS_IPSR), .LOCKUP(LOCKUP), .ENABLE(ENABLE),
        .CLEAR(CLEAR), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
        .RD_DATA(RD_DATA), .LEVEL(LEVEL), .OVERFLOW(OVERFLOW),
        .DROPS(DROPS), .FROZEN(FROZEN)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        en;
        logic        clr;
        logic        rdy;
        logic [5:0]  ipsr;
        logic [30:0] pc;
        logic        ev;
        logic [2:0]  lvl;
        logic [52:0] dat;
    } vec_t;

    vec_t tbl[21];

    function automatic logic [52:0] mkd(input logic [15:0] ts,
                                         input logic [5:0] ip,
                                         input logic [30:0] pc);
`ifdef CM0DS_PC_TRACE_TS_EN
        return {ts, ip, pc};
`else
        return {16'h0, ip, pc};
`endif
    endfunction

    function automatic vec_t mkv(input logic en, input logic clr,
                                 input logic rdy, input logic [5:0] ip,
                                 input logic [30:0] pc, input logic ev,
                                 input logic [2:0] lvl,
                                 input logic [52:0] dat);
        vec_t v;
        v.en = en; v.clr = clr; v.rdy = rdy; v.ipsr = ip; v.pc = pc;
        v.ev = ev; v.lvl = lvl; v.dat = dat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic clr, input logic rdy,
                        input logic lk, input logic [5:0] ip,
                        input logic [30:0] pc);
        ENABLE = en; CLEAR = clr; RD_READY = rdy; LOCKUP = lk;
        VIS_IPSR = ip; VIS_PC = pc;
        @(negedge HCLK);
    endtask

    task automatic chk_head(input string name, input logic [2:0] lvl,
                            input logic [52:0] dat);
        chk({name, "_valid"}, 64'(RD_VALID), 64'(lvl != 3'd0));
        chk({name, "_level"}, 64'(LEVEL), 64'(lvl));
        chk({name, "_data"}, 64'(RD_DATA), 64'(dat));
    endtask

    initial begin
        logic [52:0] heads [4];

        tbl[0]  = mkv(1, 0, 0, 0, 31'h100, 0, 0, '0);
        tbl[1]  = mkv(1, 0, 0, 0, 31'h100, 1, 1, mkd(0, 0, 31'h100));
        tbl[2]  = mkv(1, 0, 0, 0, 31'h101, 1, 1, mkd(0, 0, 31'h100));
        tbl[3]  = mkv(1, 0, 0, 0, 31'h103, 1, 1, mkd(0, 0, 31'h100));
        tbl[4]  = mkv(1, 0, 0, 0, 31'h104, 1, 1, mkd(0, 0, 31'h100));
        tbl[5]  = mkv(1, 0, 0, 0, 31'h104, 1, 1, mkd(0, 0, 31'h100));
        tbl[6]  = mkv(1, 0, 0, 0, 31'h104, 1, 1, mkd(0, 0, 31'h100));
        tbl[7]  = mkv(1, 0, 0, 0, 31'h200, 1, 2, mkd(0, 0, 31'h100));
        tbl[8]  = mkv(1, 0, 1, 0, 31'h200, 1, 1, mkd(6, 0, 31'h200));
        tbl[9]  = mkv(1, 0, 1, 0, 31'h200, 0, 0, '0);
        tbl[10] = mkv(1, 0, 0, 0, 31'h1FF, 1, 1, mkd(3, 0, 31'h1FF));
        tbl[11] = mkv(1, 0, 0, 3, 31'h200, 1, 2, mkd(3, 0, 31'h1FF));
        tbl[12] = mkv(1, 0, 0, 3, 31'h202, 1, 2, mkd(3, 0, 31'h1FF));
        tbl[13] = mkv(0, 0, 0, 3, 31'h500, 1, 2, mkd(3, 0, 31'h1FF));
        tbl[14] = mkv(0, 0, 0, 3, 31'h600, 1, 2, mkd(3, 0, 31'h1FF));
        tbl[15] = mkv(0, 1, 0, 3, 31'h600, 0, 0, '0);
        tbl[16] = mkv(1, 0, 0, 0, 31'h7FFFFFFF, 0, 0, '0);
        tbl[17] = mkv(1, 0, 0, 0, 31'h7FFFFFFF, 1, 1,
                      mkd(0, 0, 31'h7FFFFFFF));
        tbl[18] = mkv(1, 0, 0, 0, 31'h0, 1, 1, mkd(0, 0, 31'h7FFFFFFF));
        tbl[19] = mkv(1, 0, 0, 0, 31'h1, 1, 1, mkd(0, 0, 31'h7FFFFFFF));
        tbl[20] = mkv(0, 1, 0, 0, 31'h1, 0, 0, '0);

        #1 HRESET = 1'b1;
        #1;
        chk("rst_valid", 64'(RD_VALID), 64'(0));
        chk("rst_level", 64'(LEVEL), 64'(0));
        chk("rst_data", 64'(RD_DATA), 64'(0));
        chk("rst_ovf", 64'(OVERFLOW), 64'(0));
        chk("rst_drops", 64'(DROPS), 64'(0));
        chk("rst_frozen", 64'(FROZEN), 64'(0));
        @(negedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].en, tbl[i].clr, tbl[i].rdy, 1'b0,
                 tbl[i].ipsr, tbl[i].pc);
            chk($sformatf("vec%0d_valid", i), 64'(RD_VALID),
                64'(tbl[i].ev));
            chk($sformatf("vec%0d_level", i), 64'(LEVEL),
                64'(tbl[i].lvl));
            chk($sformatf("vec%0d_data", i), 64'(RD_DATA),
                64'(tbl[i].dat));
        end

        step(1, 0, 0, 0, 0, 31'h1000);
        step(1, 0, 0, 0, 0, 31'h1000);
        step(1, 0, 0, 0, 0, 31'h2000);
        step(1, 0, 0, 0, 0, 31'h3000);
        step(1, 0, 0, 0, 0, 31'h4000);
        chk("full_ovf", 64'(OVERFLOW), 64'(0));
        step(1, 0, 0, 0, 0, 31'h5000);
        step(1, 0, 0, 0, 0, 31'h6000);
        chk_head("ovf", 3'd4, mkd(0, 0, 31'h1000));
        chk("ovf_flag", 64'(OVERFLOW), 64'(1));
        chk("ovf_drops", 64'(DROPS), 64'(2));

        step(1, 0, 1, 0, 0, 31'h7000);
        chk_head("fullpop", 3'd4, mkd(1, 0, 31'h2000));
        chk("fullpop_drops", 64'(DROPS), 64'(2));

        for (int i = 0; i < 260; i++)
            step(1, 0, 0, 0, 0, (i % 2 == 0) ? 31'h8000 : 31'h9000);
        chk("sat_drops", 64'(DROPS), 64'(255));
        chk_head("sat_hold", 3'd4, mkd(1, 0, 31'h2000));

        heads[0] = mkd(1, 0, 31'h3000);
        heads[1] = mkd(1, 0, 31'h4000);
        heads[2] = mkd(1, 0, 31'h7000);
        heads[3] = '0;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 1, 0, 0, 31'h9000);
            chk_head($sformatf("drain%0d", i), 3'(3 - i), heads[i]);
        end

        step(0, 1, 0, 0, 0, 31'h9000);
        chk("clr_ovf", 64'(OVERFLOW), 64'(0));
        chk("clr_drops", 64'(DROPS), 64'(0));

        step(1, 0, 0, 0, 0, 31'h100);
        step(1, 0, 0, 0, 0, 31'h100);
        step(1, 0, 1, 0, 3, 31'h400);
        chk_head("exc", 3'd1, mkd(1, 3, 31'h400));
        step(1, 0, 0, 1, 3, 31'h402);
        chk_head("lock", 3'd2, mkd(1, 3, 31'h400));
        chk("lock_frozen", 64'(FROZEN), 64'(1));
        step(1, 0, 0, 0, 3, 31'h900);
        step(1, 0, 0, 1, 0, 31'h50);
        chk("halt_level", 64'(LEVEL), 64'(2));
        chk("halt_frozen", 64'(FROZEN), 64'(1));
        step(1, 0, 1, 0, 0, 31'h60);
        chk_head("halt_drain", 3'd1, mkd(1, 3, 31'h402));
        chk("halt_drain_frozen", 64'(FROZEN), 64'(1));
        step(1, 1, 0, 0, 0, 31'h60);
        chk("unlock_level", 64'(LEVEL), 64'(0));
        chk("unlock_frozen", 64'(FROZEN), 64'(0));
        step(1, 0, 0, 0, 0, 31'h60);
        chk_head("reprime", 3'd1, mkd(0, 0, 31'h60));

        step(1, 0, 0, 0, 0, 31'h800);
        step(1, 0, 0, 0, 0, 31'h900);
        chk("pre_rst_level", 64'(LEVEL), 64'(3));
        ENABLE = 1'b0;
        #2 HRESET = 1'b1;
        #1;
        chk("arst_valid", 64'(RD_VALID), 64'(0));
        chk("arst_level", 64'(LEVEL), 64'(0));
        chk("arst_ovf", 64'(OVERFLOW), 64'(0));
        chk("arst_data", 64'(RD_DATA), 64'(0));
        @(negedge HCLK);
        HRESET = 1'b0;
        step(1, 0, 0, 0, 0, 31'h40);
        chk("restart_prime", 64'(LEVEL), 64'(0));
        step(1, 0, 0, 0, 0, 31'h40);
        chk_head("restart", 3'd1, mkd(0, 0, 31'h40));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
